// File: rtl/systolic_feed_ctrl.sv
// Left-edge feed sequencer for a systolic array: reads NUM_ROWS row FIFOs in a
// diagonal skew (row i starts i steps after row 0), all rows advancing or stalling together.
module systolic_feed_ctrl #(
    parameter int unsigned NUM_ROWS  = 4,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [NUM_ROWS-1:0]  fifo_empty,
    output logic [NUM_ROWS-1:0]  fifo_rdreq,
    output logic [NUM_ROWS-1:0]  row_valid,
    output logic                 busy,
    output logic                 stall,
    output logic                 done
);

    localparam int unsigned STEP_WIDTH = LEN_WIDTH + $clog2(NUM_ROWS) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [STEP_WIDTH-1:0] last_step;
    logic [NUM_ROWS-1:0]   need;
    logic                  run;
    logic                  blocked;

    // Outputs are gated by rstn so a mid-pass reset silences reads in the reset cycle itself.
    assign run       = rstn && (state_q == ST_RUN);
    assign last_step = STEP_WIDTH'(len_q) + STEP_WIDTH'(NUM_ROWS) - STEP_WIDTH'(2);

    always_comb begin
        need = '0;
        for (int i = 0; i < int'(NUM_ROWS); i++) begin
            need[i] = run
                   && (step_q >= STEP_WIDTH'(i))
                   && (step_q <  STEP_WIDTH'(i) + STEP_WIDTH'(len_q));
        end
    end

    assign blocked    = |(need & fifo_empty);
    assign fifo_rdreq = blocked ? '0 : need;
    assign row_valid  = fifo_rdreq;
    assign busy       = run;
    assign stall      = run && blocked;
    assign done       = rstn && (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d  = len;
                    step_d = '0;
                    state_d = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (!blocked) begin
                    if (step_q == last_step) begin
                        state_d = ST_DONE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + STEP_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized scoreboard bench for systolic_feed_ctrl: the driver queues the expected
// skewed read pattern per pass, a negedge monitor consumes it against the DUT outputs.
module tb_systolic_feed_ctrl;

    localparam int unsigned NR = 4;
    localparam int unsigned LW = 8;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [LW-1:0] len;
    logic [NR-1:0] fifo_empty;
    logic [NR-1:0] fifo_rdreq;
    logic [NR-1:0] row_valid;
    logic          busy;
    logic          stall;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [NR-1:0] exp_q[$];
    int            pass_q[$];
    int            rd_cnt[NR];
    bit            mon_idle = 1'b1;
    bit            mon_run = 1'b0;
    bit            exp_done_next = 1'b0;

    systolic_feed_ctrl #(.NUM_ROWS(NR), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .len        (len),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .row_valid  (row_valid),
        .busy       (busy),
        .stall      (stall),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle against the queued step patterns and pass bookkeeping.
    always @(negedge clk) begin
        bit            nd;
        bit            rn;
        bit            blk;
        logic [NR-1:0] head;
        int            exp_len;
        if (!rstn) begin
            chk("rst_rdreq", 32'(fifo_rdreq), 32'(0));
            chk("rst_row_valid", 32'(row_valid), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_stall", 32'(stall), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            mon_idle      = 1'b1;
            mon_run       = 1'b0;
            exp_done_next = 1'b0;
            foreach (rd_cnt[i]) rd_cnt[i] = 0;
        end else begin
            nd = 1'b0;
            rn = mon_run;
            chk("done", 32'(done), 32'(exp_done_next));
            chk("busy", 32'(busy), 32'(mon_run));
            chk("row_valid", 32'(row_valid), 32'(fifo_rdreq));
            if (mon_run) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL exp_underflow got busy=%0b want no more steps at %0t", busy, $time);
                    rn = 1'b0;
                end else begin
                    head = exp_q[0];
                    blk  = |(head & fifo_empty);
                    chk("stall", 32'(stall), 32'(blk));
                    chk("rdreq", 32'(fifo_rdreq), blk ? 32'(0) : 32'(head));
                    if (!blk) begin
                        void'(exp_q.pop_front());
                        for (int i = 0; i < int'(NR); i++) rd_cnt[i] += int'(head[i]);
                        if (exp_q.size() == 0) begin
                            nd = 1'b1;
                            rn = 1'b0;
                        end
                    end
                end
            end else begin
                chk("idle_rdreq", 32'(fifo_rdreq), 32'(0));
                chk("idle_stall", 32'(stall), 32'(0));
            end
            if (mon_idle && start) begin
                mon_idle = 1'b0;
                if (len == '0) nd = 1'b1;
                else           rn = 1'b1;
            end
            if (done) begin
                if (pass_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done got done=1 want no pass pending at %0t", $time);
                end else begin
                    exp_len = pass_q.pop_front();
                    for (int i = 0; i < int'(NR); i++) chk("row_reads", 32'(rd_cnt[i]), 32'(exp_len));
                end
                foreach (rd_cnt[i]) rd_cnt[i] = 0;
                mon_idle = 1'b1;
            end
            exp_done_next = nd;
            mon_run       = rn;
        end
    end

    // One pass: queue the expected per-step read vectors, then drive empties until done.
    task automatic run_pass(input int l, input int pct, input bit rstart,
                            input int st_at, input logic [NR-1:0] st_mask, input int st_len,
                            input int abort_at);
        logic [NR-1:0] v;
        bit            finished;
        @(posedge clk); #1;
        start      = 1'b1;
        len        = LW'(l);
        fifo_empty = '0;
        for (int s = 0; s < l + int'(NR) - 1 && l > 0; s++) begin
            v = '0;
            for (int i = 0; i < int'(NR); i++) v[i] = (i <= s) && (s < i + l);
            exp_q.push_back(v);
        end
        pass_q.push_back(l);
        finished = 1'b0;
        for (int j = 0; j < 6000 && !finished; j++) begin
            @(posedge clk); #1;
            if (j == abort_at) begin
                rstn       = 1'b0;
                start      = 1'b0;
                fifo_empty = '0;
                exp_q.delete();
                pass_q.delete();
                @(posedge clk); #1;
                rstn = 1'b1;
                return;
            end
            start = rstart && ($urandom_range(0, 3) == 0);
            len   = LW'($urandom);
            if (st_len > 0 && j >= st_at && j < st_at + st_len) fifo_empty = st_mask;
            else for (int i = 0; i < int'(NR); i++) fifo_empty[i] = (int'($urandom_range(0, 99)) < pct);
            @(negedge clk);
            if (done) finished = 1'b1;
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no done want done within 6000 cycles (len=%0d)", l);
        end
        @(posedge clk); #1;
        start      = 1'b0;
        fifo_empty = '0;
    endtask

    initial begin
        int l;
        int ab;
        rstn       = 1'b0;
        start      = 1'b1;
        len        = LW'(5);
        fifo_empty = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn  = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;

        run_pass(3, 0, 1'b0, -1, '0, 0, -1);          // basic skew
        run_pass(3, 0, 1'b0, 2, 4'b0100, 2, -1);      // stall on row 2 at step 2
        run_pass(3, 0, 1'b0, 0, 4'b1000, 1, -1);      // inactive row empty
        run_pass(0, 0, 1'b0, -1, '0, 0, -1);          // zero-length pass
        run_pass(3, 0, 1'b1, -1, '0, 0, -1);          // start pulses while busy
        run_pass(4, 0, 1'b0, -1, '0, 0, 3);           // reset mid-pass
        run_pass(2, 0, 1'b0, -1, '0, 0, -1);
        run_pass(255, 10, 1'b1, -1, '0, 0, -1);       // maximum length
        run_pass(1, 30, 1'b1, -1, '0, 0, -1);
        for (int k = 0; k < 30; k++) begin
            l  = int'($urandom_range(0, 12));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_pass(l, int'($urandom_range(0, 40)), 1'b1, -1, '0, 0, ab);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        chk("pass_q_drained", 32'(pass_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
